// File: rtl/mem_ctrl_rr_pkg.sv
// mem_ctrl_rr_pkg: shared state, size codes and helpers
// for the round-robin byte-serial memory controller.
package mem_ctrl_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_e;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] IO_SEG = 2'b11;

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    logic [2:0] n;
    unique case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(
    input logic [31:0] raw,
    input logic [1:0]  sz,
    input logic        sgn
  );
    logic [31:0] r;
    unique case (sz)
      SZ_B:    r = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_H:    r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  i
  );
    return 8'(w >> {i, 3'b000});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching
// upward from ptr+1 with wrap; one-hot grant plus index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_rr.sv
// mem_ctrl_rr: NUM_CH-way round-robin controller serialising
// 1/2/4-byte reads and writes onto a byte-wide memory bus.
module mem_ctrl_rr #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_sign,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [32*NUM_CH-1:0]     req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        abort,
  output logic [NUM_CH-1:0]        resp_valid,
  output logic [31:0]              resp_data,
  input  logic [7:0]               mem_din,
  output logic [7:0]               mem_dout,
  output logic [ADDR_W-1:0]        mem_a,
  output logic                     mem_wr,
  input  logic                     io_buffer_full
);
  import mem_ctrl_rr_pkg::*;

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state;
  logic [IW-1:0]     ptr, ch_q, gidx;
  logic [NUM_CH-1:0] gnt, resp_q;
  logic              any, idle_ok, accept, io_stall;
  logic [ADDR_W-1:0] addr_q, mem_a_q, a_sel, nxt_a;
  logic [1:0]        sz_q, sz_raw, sz_n, cidx;
  logic              sgn_q;
  logic [31:0]       wdata_q, w_sel, lanes_q, lanes_nxt, data_q;
  logic [2:0]        cnt, n_q;
  logic [7:0]        dout_q, din_hold, cap;
  logic              rdy_d;

  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign a_sel  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign w_sel  = req_wdata[int'(gidx)*32 +: 32];
  assign sz_raw = req_size[int'(gidx)*2 +: 2];
  assign sz_n   = (sz_raw == 2'd3) ? SZ_W : sz_raw;

  assign idle_ok   = rst & rdy & (state == ST_IDLE) & ~|resp_q;
  assign accept    = idle_ok & any;
  assign req_ready = idle_ok ? gnt : '0;

  assign io_stall = (mem_a_q[17:16] == IO_SEG) & io_buffer_full;
  assign mem_wr   = (state == ST_WRITE) & rdy & ~io_stall;
  assign mem_a    = mem_a_q;
  assign mem_dout = dout_q;

  assign resp_valid = resp_q;
  assign resp_data  = data_q;

  // After a freeze mem_din already shows the next address, so
  // the byte seen in the first frozen cycle is kept for capture.
  assign cap       = rdy_d ? mem_din : din_hold;
  assign cidx      = 2'(cnt - 3'd1);
  assign lanes_nxt = lanes_q | ({24'b0, cap} << {cidx, 3'b000});
  assign nxt_a     = addr_q + ADDR_W'(cnt + 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_d    <= 1'b0;
      din_hold <= '0;
    end else begin
      rdy_d <= rdy;
      if (rdy_d) din_hold <= mem_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ptr     <= IW'(NUM_CH - 1);
      ch_q    <= '0;
      addr_q  <= '0;
      sz_q    <= SZ_B;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      n_q     <= 3'd1;
      cnt     <= '0;
      lanes_q <= '0;
      mem_a_q <= '0;
      dout_q  <= '0;
      resp_q  <= '0;
      data_q  <= '0;
    end else if (rdy) begin
      resp_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            ptr     <= gidx;
            ch_q    <= gidx;
            addr_q  <= a_sel;
            sz_q    <= sz_n;
            sgn_q   <= req_sign[gidx];
            wdata_q <= w_sel;
            n_q     <= nbytes(sz_n);
            cnt     <= '0;
            lanes_q <= '0;
            mem_a_q <= a_sel;
            dout_q  <= req_wr[gidx] ? w_sel[7:0] : 8'h00;
            state   <= req_wr[gidx] ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (abort[ch_q]) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mem_a_q <= '0;
          end else begin
            if (cnt != 3'd0) lanes_q <= lanes_nxt;
            if (cnt == n_q) begin
              resp_q[ch_q] <= 1'b1;
              data_q       <= extend(lanes_nxt, sz_q, sgn_q);
              state        <= ST_IDLE;
            end else begin
              cnt     <= cnt + 3'd1;
              mem_a_q <= (cnt == n_q - 3'd1) ? '0 : nxt_a;
            end
          end
        end
        ST_WRITE: begin
          if (!io_stall) begin
            if (cnt == n_q - 3'd1) begin
              resp_q[ch_q] <= 1'b1;
              data_q       <= '0;
              state        <= ST_IDLE;
              mem_a_q      <= '0;
              dout_q       <= '0;
            end else begin
              cnt     <= cnt + 3'd1;
              mem_a_q <= nxt_a;
              dout_q  <= byte_of(wdata_q, 2'(cnt + 3'd1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// tb_mem_ctrl_rr: directed scoreboard bench for mem_ctrl_rr
// with a byte-wide synchronous memory model.
module tb_mem_ctrl_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_wr = '0;
  logic [3:0]  req_size = '0;
  logic [1:0]  req_sign = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready;
  logic [1:0]  abort = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:262143];

  mem_ctrl_rr #(.NUM_CH(2), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .req_valid      (req_valid),
    .req_wr         (req_wr),
    .req_size       (req_size),
    .req_sign       (req_sign),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .abort          (abort),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= mem[mem_a[17:0]];
    if (mem_wr) mem[mem_a[17:0]] <= mem_dout;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // monitor: every response pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && resp_valid != 2'b00) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got valid %b data 0x%08h expected none",
                 resp_valid, resp_data);
      end else begin
        e = expq.pop_front();
        chk("resp_ch", 32'(resp_valid), 32'(1) << e.ch);
        chk("resp_data", resp_data, e.data);
      end
    end
  end

  task automatic do_req(input int ch, input logic wr,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input bit push);
    int   t;
    exp_t e;
    req_wr[ch]            = wr;
    req_size[2*ch +: 2]   = sz;
    req_sign[ch]          = sg;
    req_addr[32*ch +: 32] = a;
    req_wdata[32*ch +: 32] = wd;
    req_valid[ch]         = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready[ch] && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("accept", 32'(req_ready[ch]), 32'd1);
    if (push) begin
      e.ch   = ch;
      e.data = exp_d;
      expq.push_back(e);
    end
    @(posedge clk);
    #1 req_valid[ch] = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   t;
    mem[18'h100] = 8'h11; mem[18'h101] = 8'h22;
    mem[18'h102] = 8'h33; mem[18'h103] = 8'h84;
    mem[18'h020] = 8'h80; mem[18'h021] = 8'hF0;
    mem[18'h040] = 8'h7F; mem[18'h041] = 8'h81;

    // reset state, with requests pending
    req_valid = 2'b11;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    gap(2);

    // word read: issue cycles 1..4, response in cycle 6
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h84332211, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("rd_mem_a", mem_a, 32'h100 + 32'(k - 1));
      chk("rd_mem_wr", 32'(mem_wr), 32'd0);
    end
    @(negedge clk);
    chk("rd_c5_valid", 32'(resp_valid), 32'd0);
    chk("rd_c5_mem_a", mem_a, 32'd0);
    @(negedge clk);
    chk("rd_c6_valid", 32'(resp_valid), 32'd1);
    gap(2);

    // signed and unsigned half, with a foreign abort
    abort = 2'b01;
    do_req(1, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'hFFFFF080, 1'b1);
    gap(6);
    abort = 2'b00;
    do_req(1, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 32'h0000F080, 1'b1);
    gap(6);

    // IO-segment byte write stalled three cycles
    io_buffer_full = 1'b1;
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h41, 32'h0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("io_stall_wr", 32'(mem_wr), 32'd0);
    end
    @(posedge clk);
    #1 io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io_wr", 32'(mem_wr), 32'd1);
    chk("io_mem_a", mem_a, 32'h30000);
    chk("io_dout", 32'(mem_dout), 32'h41);
    @(negedge clk);
    chk("io_resp", 32'(resp_valid), 32'd1);
    gap(2);
    chk("io_mem", 32'(mem[18'h30000]), 32'h41);

    // read aborted in issue cycle 2
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 2'b01;
    @(posedge clk);
    #1 abort = 2'b00;
    @(negedge clk);
    chk("abort_mem_a", mem_a, 32'd0);
    gap(6);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'hFFFFFF84, 1'b1);
    gap(5);

    // write ignores abort
    abort = 2'b10;
    do_req(1, 1'b1, 2'd3, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("wr_abort_wr", 32'(mem_wr), 32'd1);
    end
    @(negedge clk);
    chk("wr_abort_resp", 32'(resp_valid), 32'd2);
    abort = 2'b00;
    gap(2);
    chk("wr_mem", {mem[18'h203], mem[18'h202], mem[18'h201], mem[18'h200]},
        32'hDEADBEEF);

    // rdy low for two cycles mid word read
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h84332211, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rdy = 1'b0;
    @(negedge clk);
    chk("frz_mem_a1", mem_a, 32'h102);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("frz_mem_a2", mem_a, 32'h102);
    @(posedge clk);
    #1 rdy = 1'b1;
    gap(6);

    // async reset in the middle of a word write
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h300, 32'h01020304, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(mem_wr), 32'd0);
    chk("mid_rst_a", mem_a, 32'd0);
    chk("mid_rst_dout", 32'(mem_dout), 32'd0);
    chk("mid_rst_data", resp_data, 32'd0);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    gap(2);

    // both channels valid: grants alternate from channel 0
    req_wr = '0;
    req_size = '0;
    req_sign = '0;
    req_addr = {32'h41, 32'h40};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("arb_grant", 32'(req_ready), (g % 2 == 0) ? 32'd1 : 32'd2);
      e.ch   = g % 2;
      e.data = (g % 2 == 0) ? 32'h7F : 32'h81;
      expq.push_back(e);
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;

    t = 0;
    while (expq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    gap(3);
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
